// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM
// state encodings and the default memory-response timeout.
package load_store_unit_pkg;

  // Encoding of the MemSize control field.
  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10,
    SizeBad  = 2'b11
  } mem_size_e;

  // Access sequencer states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDone = 2'd2
  } lsu_state_e;

  // Default number of REQ wait cycles before an access is aborted.
  localparam int unsigned DefaultTimeout = 255;

  // True when the low address bits satisfy the natural alignment of the size.
  function automatic logic is_aligned(logic [1:0] size, logic [1:0] addr_lo);
    case (size)
      SizeByte: is_aligned = 1'b1;
      SizeHalf: is_aligned = ~addr_lo[0];
      SizeWord: is_aligned = (addr_lo == 2'b00);
      default:  is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for a little-endian word-wide data memory.
// Store side: byte enables and lane-replicated write data.
// Load side: selects the addressed byte/halfword/word from a read word and
// sign- or zero-extends it.
//   size_i     access size (MemSize encoding)
//   addr_lo_i  byte offset within the word
//   wdata_i    right-justified store data
//   rword_i    read word from memory (load register)
//   unsigned_i 1 = zero-extend loads, 0 = sign-extend
//   be_o       byte enables, bit k = lane k (all zero for the illegal size)
//   wdata_o    store data replicated across lanes
//   rdata_o    extracted and extended load data
module mem_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  input  logic        unsigned_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;
  logic        sign_fill;

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    case (size_i)
      SizeByte: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SizeHalf: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      SizeWord: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
      end
    endcase
  end

  // Move the addressed lane down to bit 0 before extending.
  assign shifted = rword_i >> {addr_lo_i, 3'b000};

  always_comb begin
    rdata_o   = shifted;
    sign_fill = 1'b0;
    case (size_i)
      SizeByte: begin
        sign_fill = ~unsigned_i & shifted[7];
        rdata_o   = {{24{sign_fill}}, shifted[7:0]};
      end
      SizeHalf: begin
        sign_fill = ~unsigned_i & shifted[15];
        rdata_o   = {{16{sign_fill}}, shifted[15:0]};
      end
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage. Runs a request/ready handshake with a
// variable-latency word-wide memory for loads and stores, stalling the core
// until the access completes or times out.
//   clk, reset         clock and synchronous active-high reset
//   MemRead/MemWrite   load/store request from control
//   MemSize            00 byte, 01 half, 10 word, 11 illegal
//   MemUnsigned        zero-extend loads when set
//   ALUResult          byte address
//   WriteData          right-justified store data
//   ReadData           extended load data (valid in DONE)
//   Stall              hold PC and register-file write
//   AccessError        illegal or misaligned access (combinational)
//   BusError           DONE cycle of a timed-out access
//   MemReq/MemWe/MemAddr/MemBe/MemWData  registered memory request
//   MemReady/MemRData  memory response
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeout
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemUnsigned,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessError,
  output logic        BusError,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemBe,
  output logic [31:0] MemWData,
  input  logic        MemReady,
  input  logic [31:0] MemRData
);

  lsu_state_e  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_q, load_d;
  logic [31:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;

  logic        any_req;
  logic        legal;
  logic [31:0] cnt_inc;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;

  mem_lane_align u_align (
    .size_i     (MemSize),
    .addr_lo_i  (ALUResult[1:0]),
    .wdata_i    (WriteData),
    .rword_i    (load_q),
    .unsigned_i (MemUnsigned),
    .be_o       (align_be),
    .wdata_o    (align_wdata),
    .rdata_o    (ReadData)
  );

  assign any_req = MemRead | MemWrite;
  assign legal   = (MemRead ^ MemWrite) && (MemSize != SizeBad) &&
                   is_aligned(MemSize, ALUResult[1:0]);
  assign cnt_inc = cnt_q + 32'd1;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    load_d      = load_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    Stall       = 1'b0;
    AccessError = 1'b0;
    BusError    = 1'b0;

    case (state_q)
      StIdle: begin
        if (any_req && legal) begin
          Stall     = 1'b1;
          req_d     = 1'b1;
          we_d      = MemWrite;
          addr_d    = {ALUResult[31:2], 2'b00};
          be_d      = align_be;
          wdata_d   = align_wdata;
          cnt_d     = 32'd0;
          timeout_d = 1'b0;
          state_d   = StReq;
        end else if (any_req) begin
          // Illegal access: flagged but never issued, so the store is dropped.
          AccessError = 1'b1;
        end
      end
      StReq: begin
        Stall = 1'b1;
        cnt_d = cnt_inc;
        // A response in the final allowed cycle wins over the timeout.
        if (MemReady) begin
          load_d  = MemRData;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StDone;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == 32'(TIMEOUT_CYCLES))) begin
          load_d    = 32'h0;
          req_d     = 1'b0;
          we_d      = 1'b0;
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        BusError = timeout_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (reset) begin
      Stall       = 1'b0;
      AccessError = 1'b0;
      BusError    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      be_q      <= 4'b0000;
      wdata_q   <= 32'h0;
      load_q    <= 32'h0;
      cnt_q     <= 32'h0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      load_q    <= load_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign MemReq   = req_q;
  assign MemWe    = we_q;
  assign MemAddr  = addr_q;
  assign MemBe    = be_q;
  assign MemWData = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, MemUnsigned, MemReady;
  logic [1:0]  MemSize;
  logic [31:0] ALUResult, WriteData, MemRData;

  logic [31:0] ReadData, MemAddr, MemWData;
  logic        Stall, AccessError, BusError, MemReq, MemWe;
  logic [3:0]  MemBe;

  logic [31:0] ReadData_t, MemAddr_t, MemWData_t;
  logic        Stall_t, AccessError_t, BusError_t, MemReq_t, MemWe_t;
  logic [3:0]  MemBe_t;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemSize(MemSize), .MemUnsigned(MemUnsigned), .ALUResult(ALUResult),
    .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
    .AccessError(AccessError), .BusError(BusError), .MemReq(MemReq), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemBe(MemBe), .MemWData(MemWData), .MemReady(MemReady),
    .MemRData(MemRData)
  );

  load_store_unit #(.TIMEOUT_CYCLES(3)) dut_to (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemSize(MemSize), .MemUnsigned(MemUnsigned), .ALUResult(ALUResult),
    .WriteData(WriteData), .ReadData(ReadData_t), .Stall(Stall_t),
    .AccessError(AccessError_t), .BusError(BusError_t), .MemReq(MemReq_t),
    .MemWe(MemWe_t), .MemAddr(MemAddr_t), .MemBe(MemBe_t), .MemWData(MemWData_t),
    .MemReady(MemReady), .MemRData(MemRData)
  );

  typedef struct {
    bit          rd, wr;
    logic [1:0]  sz;
    bit          uns;
    logic [31:0] addr, wd, rword;
    int          delay;
    bit          e_err;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd;
    int          e_stall;
  } vec_t;

  // Observations of the last access.
  bit          r_err, r_hung, r_stable, r_we, r_buserr, r_buserr_t;
  int          r_stall, r_req;
  logic [31:0] r_addr, r_wd, r_rd, r_rd_t;
  logic [3:0]  r_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(bit rd, bit wr, logic [1:0] sz, bit uns, logic [31:0] addr,
                               logic [31:0] wd, logic [31:0] rword, int delay, bit e_err,
                               logic [31:0] e_addr, logic [3:0] e_be, logic [31:0] e_wd,
                               logic [31:0] e_rd, int e_stall);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd;
    v.rword = rword; v.delay = delay; v.e_err = e_err; v.e_addr = e_addr;
    v.e_be = e_be; v.e_wd = e_wd; v.e_rd = e_rd; v.e_stall = e_stall;
    return v;
  endfunction

  // Reference model: expected results from the access rules with plain arithmetic.
  function automatic vec_t model(vec_t v);
    vec_t   o = v;
    longint nbytes, lane, mask, val, bits;
    nbytes = (v.sz == 2'd3) ? 1 : (longint'(1) << v.sz);
    lane   = longint'(v.addr % 4);
    o.e_err = (v.rd && v.wr) || (v.sz == 2'd3) || ((v.addr % nbytes) != 0);
    o.e_stall = o.e_err ? 0 : v.delay + 1;
    o.e_addr = v.addr - (v.addr % 4);
    o.e_be   = 4'(((longint'(1) << nbytes) - 1) << lane);
    case (nbytes)
      1:       o.e_wd = 32'(longint'(v.wd % 256) * 64'h01010101);
      2:       o.e_wd = 32'(longint'(v.wd % 65536) * 64'h00010001);
      default: o.e_wd = v.wd;
    endcase
    bits = nbytes * 8;
    mask = (longint'(1) << bits) - 1;
    val  = (longint'(v.rword) >> (8 * lane)) & mask;
    if (!v.uns && ((val >> (bits - 1)) & 1) == 1) val = val - (longint'(1) << bits);
    o.e_rd = 32'(val);
    return o;
  endfunction

  // Issue one access, answer it after `delay` REQ cycles, record what is seen.
  task automatic run_access(input vec_t v);
    bit fin = 0;
    int n   = 0;
    @(posedge clk); #1;
    MemRead = v.rd; MemWrite = v.wr; MemSize = v.sz; MemUnsigned = v.uns;
    ALUResult = v.addr; WriteData = v.wd; MemRData = v.rword; MemReady = 1'b0;
    r_err = 0; r_hung = 0; r_stable = 1; r_we = 0; r_buserr = 0; r_buserr_t = 0;
    r_stall = 0; r_req = 0; r_addr = '0; r_wd = '0; r_rd = '0; r_rd_t = '0; r_be = '0;
    while (!fin) begin
      @(negedge clk);
      if (n == 0) r_err = AccessError;
      if (MemReq) begin
        r_req++;
        if (r_req == 1) begin
          r_addr = MemAddr; r_be = MemBe; r_wd = MemWData; r_we = MemWe;
        end else if (MemAddr !== r_addr || MemBe !== r_be || MemWData !== r_wd ||
                     MemWe !== r_we) begin
          r_stable = 0;
        end
        MemReady = (r_req == v.delay);
      end else begin
        MemReady = 1'b0;
      end
      if (!Stall) begin
        r_rd = ReadData; r_buserr = BusError; r_rd_t = ReadData_t; r_buserr_t = BusError_t;
        fin = 1;
      end else begin
        r_stall++;
        n++;
        if (n > 40) begin
          r_hung = 1;
          fin = 1;
        end
      end
    end
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0; MemReady = 1'b0;
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    run_access(v);
    chk({tag, " bounded"}, 32'(r_hung), 32'd0);
    chk({tag, " AccessError"}, 32'(r_err), 32'(v.e_err));
    chk({tag, " stall cycles"}, r_stall, v.e_stall);
    if (v.e_err) begin
      chk({tag, " no request"}, r_req, 0);
    end else begin
      chk({tag, " REQ cycles"}, r_req, v.delay);
      chk({tag, " MemAddr"}, r_addr, v.e_addr);
      chk({tag, " MemBe"}, 32'(r_be), 32'(v.e_be));
      chk({tag, " MemWData"}, r_wd, v.e_wd);
      chk({tag, " MemWe"}, 32'(r_we), 32'(v.wr));
      chk({tag, " held stable"}, 32'(r_stable), 32'd1);
      chk({tag, " BusError"}, 32'(r_buserr), 32'd0);
      if (v.rd) chk({tag, " ReadData"}, r_rd, v.e_rd);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; MemReady = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  vec_t tbl[11];
  vec_t v;
  int   cnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    // Reset with an illegal request present: outputs must stay quiet.
    reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b1; MemSize = 2'd2; MemUnsigned = 1'b0;
    ALUResult = 32'h1002; WriteData = 32'hFFFF_FFFF; MemReady = 1'b1; MemRData = 32'h5555_5555;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset Stall", 32'(Stall), 32'd0);
    chk("reset AccessError", 32'(AccessError), 32'd0);
    chk("reset BusError", 32'(BusError), 32'd0);
    chk("reset MemReq", 32'(MemReq), 32'd0);
    chk("reset MemWe", 32'(MemWe), 32'd0);
    chk("reset MemAddr", MemAddr, 32'h0);
    chk("reset MemBe", 32'(MemBe), 32'd0);
    chk("reset MemWData", MemWData, 32'h0);
    chk("reset ReadData", ReadData, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemReady = 1'b0;

    // Response in the last allowed cycle completes normally on the timeout DUT.
    v = model(mkv(1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hCAFE_BABE, 3, 0, 0, 0, 0, 0, 0));
    check_vec(v, "late-ok");
    chk("late-ok short-timeout BusError", 32'(r_buserr_t), 32'd0);
    chk("late-ok short-timeout ReadData", r_rd_t, 32'hCAFE_BABE);

    // No response: short-timeout DUT aborts after 3 REQ cycles.
    @(posedge clk); #1;
    MemRead = 1'b1; MemWrite = 1'b0; MemSize = 2'd2; ALUResult = 32'h104; MemReady = 1'b0;
    cnt = 0;
    @(negedge clk);
    while (Stall_t && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("timeout stall cycles", cnt, 4);
    chk("timeout BusError", 32'(BusError_t), 32'd1);
    chk("timeout ReadData", ReadData_t, 32'h0);
    @(posedge clk); #1;
    MemRead = 1'b0;
    @(negedge clk);
    chk("timeout BusError one cycle", 32'(BusError_t), 32'd0);
    do_reset();

    // Directed vectors.
    tbl[0]  = mkv(0, 1, 2'd2, 0, 32'h1004, 32'hDEAD_BEEF, 32'h0, 1,
                  0, 32'h1004, 4'hF, 32'hDEAD_BEEF, 32'h0, 2);
    tbl[1]  = mkv(1, 0, 2'd0, 0, 32'h2003, 32'h0, 32'h8012_3456, 1,
                  0, 32'h2000, 4'h8, 32'h0, 32'hFFFF_FF80, 2);
    tbl[2]  = mkv(1, 0, 2'd0, 1, 32'h2003, 32'h0, 32'h8012_3456, 1,
                  0, 32'h2000, 4'h8, 32'h0, 32'h0000_0080, 2);
    tbl[3]  = mkv(0, 1, 2'd1, 0, 32'h0012, 32'h0000_ABCD, 32'h0, 1,
                  0, 32'h0010, 4'hC, 32'hABCD_ABCD, 32'h0, 2);
    tbl[4]  = mkv(1, 0, 2'd2, 0, 32'h1002, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0, 0);
    tbl[5]  = mkv(1, 0, 2'd1, 0, 32'h0001, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0, 0);
    tbl[6]  = mkv(1, 0, 2'd2, 0, 32'h0040, 32'h0, 32'h1234_5678, 4,
                  0, 32'h0040, 4'hF, 32'h0, 32'h1234_5678, 5);
    tbl[7]  = mkv(1, 1, 2'd2, 0, 32'h0000, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0, 0);
    tbl[8]  = mkv(0, 1, 2'd3, 0, 32'h0004, 32'h1, 32'h0, 1, 1, 0, 0, 0, 0, 0);
    tbl[9]  = mkv(1, 0, 2'd1, 0, 32'h0002, 32'h0, 32'h8001_7FFF, 2,
                  0, 32'h0000, 4'hC, 32'h0, 32'hFFFF_8001, 3);
    tbl[10] = mkv(0, 1, 2'd0, 0, 32'h0301, 32'h0000_00A5, 32'h0, 3,
                  0, 32'h0300, 4'h2, 32'hA5A5_A5A5, 32'h0, 4);
    for (int i = 0; i < 11; i++) check_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset during the second REQ cycle, then a stray response.
    @(posedge clk); #1;
    MemRead = 1'b1; MemWrite = 1'b0; MemSize = 2'd2; MemUnsigned = 1'b0;
    ALUResult = 32'h200; MemReady = 1'b0; MemRData = 32'h7777_7777;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst-req first REQ MemReq", 32'(MemReq), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst-req Stall under reset", 32'(Stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; MemRead = 1'b0;
    @(negedge clk);
    chk("rst-req MemReq after", 32'(MemReq), 32'd0);
    chk("rst-req Stall after", 32'(Stall), 32'd0);
    MemReady = 1'b1;
    @(posedge clk); #1;
    MemReady = 1'b0;
    @(negedge clk);
    chk("stray ready MemReq", 32'(MemReq), 32'd0);
    chk("stray ready Stall", 32'(Stall), 32'd0);
    chk("stray ready ReadData", ReadData, 32'h0);
    v = model(mkv(1, 0, 2'd2, 0, 32'h204, 32'h0, 32'h1111_2222, 2, 0, 0, 0, 0, 0, 0));
    check_vec(v, "post-reset");

    // Randomized accesses against the reference model.
    for (int i = 0; i < 60; i++) begin
      int k, s;
      k = $urandom_range(0, 9);
      s = $urandom_range(0, 7);
      v.rd    = (k < 5) || (k == 9);
      v.wr    = (k >= 5);
      v.sz    = (s == 7) ? 2'd3 : 2'(s % 3);
      v.uns   = 1'($urandom_range(0, 1));
      v.addr  = $urandom;
      v.wd    = $urandom;
      v.rword = $urandom;
      v.delay = $urandom_range(1, 5);
      v = model(v);
      check_vec(v, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage directly downstream of the execute-stage ALU in the single-cycle MIPS datapath. Takes ALUResult as the byte address and, for loads and stores, runs a request/ready handshake with a variable-latency word-wide data memory. It stalls the core while the access is outstanding. It generates byte enables and lane-replicated store data, and returns sign- or zero-extended load data to the write-back mux.

## Interface
- TIMEOUT_CYCLES, 255: maximum wait cycles in REQ before abort; 0 disables the timeout.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- MemRead  in  1  load request from the control unit.
- MemWrite  in  1  store request from the control unit.
- MemSize  in  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- MemUnsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- ALUResult  in  32  byte address.
- WriteData  in  32  store data, right-justified.
- ReadData  out  32  extended load data; valid in DONE.
- Stall  out  1  holds PC and register-file write while high.
- AccessError  out  1  combinational pulse for a misaligned or illegal access.
- BusError  out  1  high for exactly the DONE cycle of a timed-out access.
- MemReq  out  1  memory request, registered.
- MemWe  out  1  1 = write, registered.
- MemAddr  out  32  word address {ALUResult[31:2],2'b00}, registered.
- MemBe  out  4  byte enables, registered; bit k = byte lane k (little-endian).
- MemWData  out  32  lane-replicated store data, registered.
- MemReady  in  1  memory completes the request in this cycle.
- MemRData  in  32  read word; valid when MemReady is high.

## Operation
- FSM states are IDLE, REQ and DONE. Reset puts the FSM in IDLE.
- Access is defined as MemRead^MemWrite, with MemSize≠11 and the address aligned.
- Alignment rules:
  - Halfword requires ALUResult[0]=0.
  - Word requires ALUResult[1:0]=00.
  - Byte is always aligned.
- AccessError=1 in IDLE when MemRead|MemWrite is high and the access is illegal. Illegal means any of: both MemRead and MemWrite high, MemSize=11, or misaligned.
  - On AccessError there is no request and no stall, and the store is dropped.
- IDLE with a legal access:
  - Stall=1 combinationally.
  - At the clock edge, register MemReq=1, MemWe, MemAddr, MemBe and MemWData, and go to REQ.
- REQ:
  - Stall=1; outputs are held stable.
  - Wait counter increments each cycle.
  - If MemReady=1: capture MemRData into the load register, drop MemReq, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0): drop MemReq, clear the load register to 0, set the timeout flag, go to DONE.
- DONE:
  - Stall=0, and ReadData is driven from the load register.
  - BusError equals the timeout flag.
  - Go to IDLE unconditionally; the core advances the PC at this edge.
- Byte enables and store data by size:
  - Byte: MemBe=1<<ALUResult[1:0]; MemWData={4{WriteData[7:0]}}.
  - Half: MemBe = ALUResult[1] ? 1100 : 0011; MemWData={2{WriteData[15:0]}}.
  - Word: MemBe=1111; MemWData=WriteData.
- Load extraction: shift the load register right by 8·ALUResult[1:0], take the low 8/16/32 bits, then extend per MemUnsigned.
- For stores, ReadData is don't-care in DONE and is still driven from the load register.
- Reset values: state IDLE, MemReq=0, MemWe=0, MemAddr=0, MemBe=0, MemWData=0, load register=0, wait counter=0, timeout flag=0.
- While reset is high, Stall, AccessError and BusError are forced to 0.

## Timing
- Minimum latency for a legal access is 3 cycles:
  - IDLE (Stall=1), then REQ with MemReady=1 in its first cycle, then DONE (Stall=0).
  - Each extra wait cycle in REQ adds one cycle.
- A MemReady seen in IDLE or DONE is ignored.
- Reset during REQ: at the reset edge go to IDLE and drop MemReq. A late response is ignored.
- TIMEOUT_CYCLES=N aborts at the end of the Nth REQ cycle with no MemReady. If MemReady arrives in that Nth cycle, the access completes normally and there is no BusError.
- The core must hold the instruction inputs stable while Stall=1 and through DONE.

## Structure
- Shared package/include holds:
  - MemSize encodings.
  - The FSM state encodings (IDLE=2'd0, REQ=2'd1, DONE=2'd2).
  - The default timeout constant.
- One sub-module, mem_lane_align, is combinational. It covers store-side MemBe/MemWData generation and load-side extraction/extension, so a bench can test it standalone.

## Test plan
- Word store: ALUResult=0x1004, WriteData=0xDEADBEEF, MemReady tied 1 → MemAddr=0x1004, MemBe=1111, MemWe=1 for one REQ cycle; Stall high for exactly 2 cycles.
- Signed byte load: ALUResult=0x2003, MemRData=0x80123456 → ReadData=0xFFFFFF80; same access with MemUnsigned=1 → 0x00000080.
- Halfword store at 0x10: ALUResult=0x0012, WriteData=0x0000ABCD → MemBe=1100, MemWData=0xABCDABCD.
- Misaligned access: word at 0x1002 or half at 0x0001 → AccessError=1, Stall=0, MemReq stays 0.
- Wait states: MemReady asserted on the 4th REQ cycle → Stall high for 5 cycles, no BusError. With TIMEOUT_CYCLES=3 and no MemReady → BusError=1 in DONE, ReadData=0.
- Reset in the 2nd REQ cycle → next cycle: IDLE, MemReq=0, Stall=0; a subsequent MemReady pulse has no effect.
